// File: rtl/ising_run_ctrl_pkg.sv
// Shared state encoding and default parameter values for the Ising run sequencer.
package ising_run_ctrl_pkg;

  localparam logic [2:0] RUN_IDLE   = 3'd0;
  localparam logic [2:0] RUN_HOLD   = 3'd1;
  localparam logic [2:0] RUN_RUN    = 3'd2;
  localparam logic [2:0] RUN_SAMPLE = 3'd3;
  localparam logic [2:0] RUN_RESULT = 3'd4;

  localparam int DEF_N           = 8;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = RUN_IDLE,
    ST_HOLD   = RUN_HOLD,
    ST_RUN    = RUN_RUN,
    ST_SAMPLE = RUN_SAMPLE,
    ST_RESULT = RUN_RESULT
  } run_state_t;

  // The array is enabled only while it oscillates and while its levels settle through the synchroniser.
  function automatic logic array_enabled(input run_state_t s);
    return (s == ST_RUN) || (s == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/ising_run_ctrl_sync_bus.sv
// Per-bit flop-chain synchroniser for asynchronous oscillator-domain levels.
// Latency STAGES clocks; no backpressure, samples every cycle.
module sync_bus #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer: hold array in reset, release for a programmed length, capture synchronised spins.
// Result after HOLD_CYCLES+len+SYNC_STAGES clocks; result held in RESULT until result_ready.
module ising_run_ctrl
  import ising_run_ctrl_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             abort,
  output logic             busy,
  output logic             ising_rstn,
  input  logic [N-1:0]     spin_in,
  output logic [N-1:0]     spin_out,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SYNC_STAGES - 1);

  run_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [N-1:0]     spin_sync;
  logic             capture;

  sync_bus #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (spin_in),
    .q    (spin_sync)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_HOLD;
          len_nxt   = (run_cycles == '0) ? CNT_W'(1) : run_cycles;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
          cnt_nxt   = len_q - CNT_W'(1);
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_SAMPLE;
          cnt_nxt   = SAMPLE_LOAD;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_RESULT;
          capture   = 1'b1;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      ST_RESULT: begin
        // A start in the accepting cycle is dropped; the requester re-asserts it.
        if (result_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ising_rstn is its own flop, decoded from the next state, so the array net never glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      ising_rstn <= 1'b0;
      spin_out   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      len_q      <= len_nxt;
      ising_rstn <= array_enabled(state_nxt);
      if (capture) spin_out <= spin_sync;
    end
  end

  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_RESULT);

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed self-checking bench for ising_run_ctrl with default parameters.
module tb_ising_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] run_cycles;
  logic        abort;
  logic        busy;
  logic        ising_rstn;
  logic [7:0]  spin_in;
  logic [7:0]  spin_out;
  logic        result_valid;
  logic        result_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ising_run_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .run_cycles   (run_cycles),
    .abort        (abort),
    .busy         (busy),
    .ising_rstn   (ising_rstn),
    .spin_in      (spin_in),
    .spin_out     (spin_out),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start across one edge (edge t); returns 1 ns after it, i.e. at sample index k=1.
  task automatic pulse_start(input logic [15:0] rc);
    start      = 1'b1;
    run_cycles = rc;
    step();
    start      = 1'b0;
  endtask

  // Observe ncyc samples starting at k=1; hi counts cycles with ising_rstn high.
  task automatic observe(input int ncyc, output int hi, output int first_hi,
                         output int first_v, output logic [7:0] cap, output logic rstn_at_v);
    hi = 0; first_hi = 0; first_v = 0; cap = '0; rstn_at_v = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      if (ising_rstn) begin
        hi++;
        if (first_hi == 0) first_hi = k;
      end
      if (result_valid && first_v == 0) begin
        first_v   = k;
        cap       = spin_out;
        rstn_at_v = ising_rstn;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; run_cycles = '0; abort = 1'b0;
    spin_in = '0; result_ready = 1'b1;
    #3;
    n_checks++; if (ising_rstn !== 1'b0) begin n_fail++; $display("FAIL reset_ising_rstn got %b want 0", ising_rstn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid got %b want 0", result_valid); end
    n_checks++; if (spin_out !== 8'h00) begin n_fail++; $display("FAIL reset_spin_out got %h want 00", spin_out); end
    #20 rstn = 1'b1;
    step();
  endtask

  task automatic test_basic_run();
    int hi, fh, fv; logic [7:0] cap; logic rv;
    spin_in = 8'hA5; result_ready = 1'b1;
    pulse_start(16'd10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_start got %b want 1", busy); end
    observe(24, hi, fh, fv, cap, rv);
    n_checks++; if (hi != 12) begin n_fail++; $display("FAIL basic_rstn_high_cycles got %0d want 12", hi); end
    n_checks++; if (fh != 5) begin n_fail++; $display("FAIL basic_rstn_rise got %0d want 5", fh); end
    n_checks++; if (fv != 17) begin n_fail++; $display("FAIL basic_valid_at got %0d want 17", fv); end
    n_checks++; if (cap !== 8'hA5) begin n_fail++; $display("FAIL basic_spin_out got %h want a5", cap); end
    n_checks++; if (rv !== 1'b0) begin n_fail++; $display("FAIL basic_rstn_at_valid got %b want 0", rv); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int waited;
    spin_in = 8'hA5; result_ready = 1'b0;
    pulse_start(16'd2);
    waited = 0;
    while (!result_valid && waited < 40) begin step(); waited++; end
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got %b want 1", result_valid); end
    spin_in = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1 || i == 3);
      step();
      n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held cyc %0d got %b want 1", i, result_valid); end
      n_checks++; if (spin_out !== 8'hA5) begin n_fail++; $display("FAIL bp_spin_out cyc %0d got %h want a5", i, spin_out); end
    end
    start = 1'b1; result_ready = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", result_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_on_accept_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_zero_len();
    int hi, fh, fv; logic [7:0] cap; logic rv;
    spin_in = 8'h3C; result_ready = 1'b1;
    pulse_start(16'd0);
    observe(14, hi, fh, fv, cap, rv);
    n_checks++; if (hi != 3) begin n_fail++; $display("FAIL zero_rstn_high_cycles got %0d want 3", hi); end
    n_checks++; if (fv != 8) begin n_fail++; $display("FAIL zero_valid_at got %0d want 8", fv); end
    n_checks++; if (cap !== 8'h3C) begin n_fail++; $display("FAIL zero_spin_out got %h want 3c", cap); end
  endtask

  task automatic test_abort();
    int vcount;
    spin_in = 8'h55; result_ready = 1'b1;
    pulse_start(16'd10);
    for (int k = 1; k < 7; k++) step();
    n_checks++; if (ising_rstn !== 1'b1) begin n_fail++; $display("FAIL abort_in_run got %b want 1", ising_rstn); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (ising_rstn !== 1'b0) begin n_fail++; $display("FAIL abort_ising_rstn got %b want 0", ising_rstn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (result_valid) vcount++;
      step();
    end
    n_checks++; if (vcount != 0) begin n_fail++; $display("FAIL abort_no_result got %0d want 0", vcount); end
    n_checks++; if (spin_out !== 8'h3C) begin n_fail++; $display("FAIL abort_spin_out_kept got %h want 3c", spin_out); end
  endtask

  // rc=3: SAMPLE occupies k=8,9 and capture happens at the edge leading to k=10.
  task automatic test_sync_latency();
    int hi, fh, fv; logic [7:0] cap; logic rv;
    spin_in = 8'h00; result_ready = 1'b1;
    pulse_start(16'd3);
    for (int k = 1; k < 8; k++) step();
    spin_in = 8'hFF;
    observe(6, hi, fh, fv, cap, rv);
    n_checks++; if (fv != 3) begin n_fail++; $display("FAIL sync_late_valid_at got %0d want 3", fv); end
    n_checks++; if (cap !== 8'h00) begin n_fail++; $display("FAIL sync_late_spin_out got %h want 00", cap); end
    spin_in = 8'h00;
    pulse_start(16'd3);
    for (int k = 1; k < 7; k++) step();
    spin_in = 8'hFF;
    observe(7, hi, fh, fv, cap, rv);
    n_checks++; if (cap !== 8'hFF) begin n_fail++; $display("FAIL sync_early_spin_out got %h want ff", cap); end
  endtask

  task automatic test_async_reset();
    int hi, fh, fv; logic [7:0] cap; logic rv;
    spin_in = 8'h11; result_ready = 1'b1;
    pulse_start(16'd10);
    for (int k = 1; k < 7; k++) step();
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (ising_rstn !== 1'b0) begin n_fail++; $display("FAIL arst_ising_rstn got %b want 0", ising_rstn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL arst_result_valid got %b want 0", result_valid); end
    n_checks++; if (spin_out !== 8'h00) begin n_fail++; $display("FAIL arst_spin_out got %h want 00", spin_out); end
    #1 rstn = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle_after got %b want 0", busy); end
    spin_in = 8'h5A;
    pulse_start(16'd0);
    observe(12, hi, fh, fv, cap, rv);
    n_checks++; if (fv != 8) begin n_fail++; $display("FAIL arst_rerun_valid_at got %0d want 8", fv); end
    n_checks++; if (cap !== 8'h5A) begin n_fail++; $display("FAIL arst_rerun_spin_out got %h want 5a", cap); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_sync_latency();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
